// File: rtl/jseq_shift_add_multiplier_if.sv
// Request/response bundle for the sequential shift-add multiplier.
// The master issues operands with start; the slave returns the product with busy/done.
interface jseq_shift_add_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   y;
  logic                 busy;
  logic                 done;

  modport master (output start, is_signed, a, b, input  y, busy, done);
  modport slave  (input  start, is_signed, a, b, output y, busy, done);
endinterface

// File: rtl/jseq_shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock on operand magnitudes,
// sign restored when the product is written. Result arrives WIDTH clocks after acceptance.
module jseq_shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  jseq_shift_add_multiplier_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   y_q, y_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   step_acc;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // |-2^(WIDTH-1)| still fits as a WIDTH-bit unsigned magnitude.
    mag_a = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Carry of the upper-half add is kept and shifted back in, so nothing overflows.
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    step_acc = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    case (state_q)
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          y_d     = (neg_q && (step_acc != '0)) ? -step_acc : step_acc;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request, giving back-to-back operation.
        if (bus.start) begin
          state_d = CALC;
          busy_d  = 1'b1;
          mcand_d = mag_a;
          acc_d   = {{WIDTH{1'b0}}, mag_b};
          neg_d   = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
